// File: rtl/mem_access_if.sv
// Bundle between the two requesters, the 8-word array/decoder and the
// access controller. The controller sits on the slave modport.
interface mem_access_if #(
  parameter int DATA_W = 8
);
  logic              a_req;
  logic              a_we;
  logic [0:2]        a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [0:2]        b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic              dec_select;
  logic [0:2]        dec_address;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output dec_select, dec_address, mem_we, mem_wdata, busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  dec_select, dec_address, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Round-robin two-port sequencer for the 8-word array: IDLE -> SETUP -> ACCESS
// -> RELEASE, with every output driven from a register.
module mem_access_ctrl #(
  parameter int DATA_W        = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_access_if.slave bus
);

  localparam int MAX_CYC = (SETUP_CYCLES > ACCESS_CYCLES) ? SETUP_CYCLES : ACCESS_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  phase_cnt;
  logic              last_grant_b;
  logic              grant_b;
  logic              we_lat;
  logic [0:2]        addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic              select_r;
  logic              mem_we_r;
  logic              a_ack_r;
  logic              b_ack_r;
  logic [DATA_W-1:0] a_rdata_r;
  logic [DATA_W-1:0] b_rdata_r;
  logic              busy_r;

  logic any_req;
  logic pick_b;

  // On a tie the port that was not served last wins.
  always_comb begin
    any_req = bus.a_req | bus.b_req;
    pick_b  = bus.b_req & (~bus.a_req | ~last_grant_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      last_grant_b <= 1'b1;
      grant_b      <= 1'b0;
      we_lat       <= 1'b0;
      addr_lat     <= '0;
      wdata_lat    <= '0;
      select_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      a_ack_r      <= 1'b0;
      b_ack_r      <= 1'b0;
      a_rdata_r    <= '0;
      b_rdata_r    <= '0;
      busy_r       <= 1'b0;
    end else begin
      a_ack_r <= 1'b0;
      b_ack_r <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_b      <= pick_b;
            last_grant_b <= pick_b;
            we_lat       <= pick_b ? bus.b_we    : bus.a_we;
            addr_lat     <= pick_b ? bus.b_addr  : bus.a_addr;
            wdata_lat    <= pick_b ? bus.b_wdata : bus.a_wdata;
            state        <= SETUP;
            phase_cnt    <= SETUP_LOAD;
            busy_r       <= 1'b1;
          end
        end
        SETUP: begin
          if (phase_cnt == '0) begin
            state     <= ACCESS;
            phase_cnt <= ACCESS_LOAD;
            select_r  <= 1'b1;
            mem_we_r  <= we_lat;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        ACCESS: begin
          if (phase_cnt == '0) begin
            state     <= RELEASE;
            phase_cnt <= '0;
            select_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            // Array data is still valid on this edge because select is still high.
            if (!we_lat) begin
              if (grant_b) b_rdata_r <= bus.mem_rdata;
              else         a_rdata_r <= bus.mem_rdata;
            end
            if (grant_b) b_ack_r <= 1'b1;
            else         a_ack_r <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        RELEASE: begin
          state     <= IDLE;
          phase_cnt <= '0;
          busy_r    <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          phase_cnt <= '0;
          busy_r    <= 1'b0;
          select_r  <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dec_select  = select_r;
  assign bus.dec_address = addr_lat;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_wdata   = wdata_lat;
  assign bus.a_ack       = a_ack_r;
  assign bus.b_ack       = b_ack_r;
  assign bus.a_rdata     = a_rdata_r;
  assign bus.b_rdata     = b_rdata_r;
  assign bus.busy        = busy_r;

endmodule
